// File: rtl/divider_pkg.sv
// Shared types and constants for the sequential signed divider.
package div_pkg;

    // Divisor / quotient / remainder width, dividend width, iteration count.
    localparam int DW   = 8;
    localparam int NW   = 16;
    localparam int ITER = 16;
    localparam int CW   = $clog2(ITER);

    // Largest quotient magnitudes representable in DW-bit two's complement.
    localparam logic [NW-1:0] QMAX_POS = NW'(127);
    localparam logic [NW-1:0] QMAX_NEG = NW'(128);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } state_t;

endpackage

// File: rtl/divider_if.sv
// Start/done handshake and operand/result bundle of the divider.
interface divider_if;
    import div_pkg::*;

    logic          start;
    logic [NW-1:0] dividend;
    logic [DW-1:0] divisor;
    logic          busy;
    logic          done;
    logic [DW-1:0] quotient;
    logic [DW-1:0] remainder;
    logic          overflow;
    logic          div_by_zero;

    // Requester side: issues operands, observes results.
    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, overflow, div_by_zero
    );

    // Divider side.
    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, overflow, div_by_zero
    );

endinterface

// File: rtl/divider_step.sv
// One radix-2 restoring iteration on magnitudes.
module div_step
    import div_pkg::*;
(
    input  logic [DW:0] prem,
    input  logic        bit_in,
    input  logic [DW:0] dvs,
    output logic [DW:0] prem_next,
    output logic        q_bit
);

    logic [DW+1:0] shifted;

    // Shift in the next dividend bit, trial-subtract, restore on a negative result.
    always_comb begin
        // NOTE: every signal assigned in a combinational block gets a value on
        // every path, otherwise synthesis infers a latch to hold the old value.
        shifted   = {prem, bit_in};
        // The trial difference is non-negative exactly when shifted >= divisor.
        q_bit     = (shifted >= {1'b0, dvs});
        prem_next = q_bit ? (DW+1)'(shifted - {1'b0, dvs}) : shifted[DW:0];
    end

endmodule

// File: rtl/divider.sv
// Sequential signed divider: 16-bit dividend / 8-bit divisor, fixed 17-edge latency.
module divider
    import div_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    divider_if.slave  bus
);

    state_t        state;
    state_t        next_state;
    logic          accept;

    logic [CW-1:0] count;
    logic          sign_q;
    logic          sign_r;
    logic          dbz_l;
    logic          dvd_top;   // bit 16 of |dividend|, set only for -32768
    logic [NW-1:0] dvd_sh;    // remaining dividend magnitude bits, MSB first
    logic [DW:0]   dvs_mag;
    logic [DW:0]   prem;
    logic [NW-1:0] quo_mag;

    logic [DW:0]   prem_next;
    logic          q_bit;

    logic [NW:0]   dvd_ext;
    logic [NW:0]   dvd_abs;
    logic [DW:0]   dvs_ext;
    logic [DW:0]   dvs_abs;

    logic          ovf_fix;
    logic [DW-1:0] quo_fix;
    logic [DW-1:0] rem_fix;

    assign accept = bus.start && (state == IDLE || state == DONE);

    div_step u_step (
        .prem      (prem),
        .bit_in    (dvd_sh[NW-1]),
        .dvs       (dvs_mag),
        .prem_next (prem_next),
        .q_bit     (q_bit)
    );

    // Operand magnitudes, one bit wider than the inputs so the most negative values fit.
    always_comb begin
        dvd_ext = {bus.dividend[NW-1], bus.dividend};
        dvd_abs = dvd_ext[NW] ? (~dvd_ext + 1'b1) : dvd_ext;
        dvs_ext = {bus.divisor[DW-1], bus.divisor};
        dvs_abs = dvs_ext[DW] ? (~dvs_ext + 1'b1) : dvs_ext;
    end

    // Sign fix and range check on the finished magnitudes.
    always_comb begin
        // A dividend of -32768 never reaches the 16 iterations, but any legal
        // divisor leaves its quotient magnitude at 256 or more, so it always overflows.
        ovf_fix = dvd_top || (sign_q ? (quo_mag > QMAX_NEG) : (quo_mag > QMAX_POS));
        quo_fix = sign_q ? (~quo_mag[DW-1:0] + 1'b1) : quo_mag[DW-1:0];
        rem_fix = sign_r ? (~prem[DW-1:0] + 1'b1)    : prem[DW-1:0];
    end

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values, independent of statement order.
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: if (bus.start) next_state = CALC;
            CALC: if (count == CW'(ITER - 1)) next_state = FIX;
            FIX:  next_state = DONE;
            DONE: next_state = bus.start ? CALC : IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Handshake outputs decoded from state.
    always_comb begin
        bus.busy = (state == CALC) || (state == FIX);
        bus.done = (state == DONE);
    end

    // Operand capture and iteration datapath.
    always_ff @(posedge clk) begin
        // NOTE: all datapath registers take the synchronous reset so an aborted
        // division leaves no stale partial state behind.
        if (rst) begin
            count   <= '0;
            sign_q  <= 1'b0;
            sign_r  <= 1'b0;
            dbz_l   <= 1'b0;
            dvd_top <= 1'b0;
            dvd_sh  <= '0;
            dvs_mag <= '0;
            prem    <= '0;
            quo_mag <= '0;
        end else if (accept) begin
            count   <= '0;
            sign_q  <= bus.dividend[NW-1] ^ bus.divisor[DW-1];
            sign_r  <= bus.dividend[NW-1];
            dbz_l   <= (bus.divisor == '0);
            dvd_top <= dvd_abs[NW];
            dvd_sh  <= dvd_abs[NW-1:0];
            dvs_mag <= dvs_abs;
            prem    <= '0;
            quo_mag <= '0;
        end else if (state == CALC) begin
            count   <= count + 1'b1;
            dvd_sh  <= {dvd_sh[NW-2:0], 1'b0};
            prem    <= prem_next;
            quo_mag <= {quo_mag[NW-2:0], q_bit};
        end
    end

    // Result registers, written on the edge that enters DONE and held otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.quotient    <= '0;
            bus.remainder   <= '0;
            bus.overflow    <= 1'b0;
            bus.div_by_zero <= 1'b0;
        end else if (state == FIX) begin
            if (dbz_l) begin
                bus.quotient    <= '0;
                bus.remainder   <= '0;
                bus.overflow    <= 1'b0;
                bus.div_by_zero <= 1'b1;
            end else if (ovf_fix) begin
                bus.quotient    <= '0;
                bus.remainder   <= '0;
                bus.overflow    <= 1'b1;
                bus.div_by_zero <= 1'b0;
            end else begin
                bus.quotient    <= quo_fix;
                bus.remainder   <= rem_fix;
                bus.overflow    <= 1'b0;
                bus.div_by_zero <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_divider.sv
// Scoreboard testbench for the signed divider: directed corners plus random operands.
module tb_divider;
    import div_pkg::*;

    typedef struct {
        int         n;
        int         d;
        logic [7:0] q;
        logic [7:0] r;
        logic       ovf;
        logic       dbz;
        int         done_cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];
    exp_t mon_e;
    logic prev_done = 1'b0;

    divider_if bus ();

    divider dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, req, req);
        end
    endtask

    // Reference: plain signed integer division, truncating toward zero.
    function automatic exp_t model(input int n, input int d);
        exp_t e;
        int   qi;
        int   ri;
        e.n = n;
        e.d = d;
        e.q = '0;
        e.r = '0;
        e.ovf = 1'b0;
        e.dbz = 1'b0;
        e.done_cyc = 0;
        if (d == 0) begin
            e.dbz = 1'b1;
        end else begin
            qi = n / d;
            ri = n % d;
            if (qi > 127 || qi < -128) begin
                e.ovf = 1'b1;
            end else begin
                e.q = qi[7:0];
                e.r = ri[7:0];
            end
        end
        return e;
    endfunction

    // Monitor: every done pulse pops one expectation and compares it.
    always @(negedge clk) begin
        if (bus.done) begin
            check("done_width", int'(prev_done), 0);
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done: got done with empty scoreboard, expected none");
            end else begin
                mon_e = sb.pop_front();
                check($sformatf("quotient %0d/%0d", mon_e.n, mon_e.d), int'(bus.quotient), int'(mon_e.q));
                check($sformatf("remainder %0d/%0d", mon_e.n, mon_e.d), int'(bus.remainder), int'(mon_e.r));
                check($sformatf("overflow %0d/%0d", mon_e.n, mon_e.d), int'(bus.overflow), int'(mon_e.ovf));
                check($sformatf("div_by_zero %0d/%0d", mon_e.n, mon_e.d), int'(bus.div_by_zero), int'(mon_e.dbz));
                check($sformatf("latency %0d/%0d", mon_e.n, mon_e.d), cyc, mon_e.done_cyc);
                check("busy_at_done", int'(bus.busy), 0);
            end
        end
        prev_done = bus.done;
    end

    // Called #1 after the accepting edge: record the expectation.
    task automatic push_exp(input int n, input int d);
        exp_t e;
        e = model(n, d);
        e.done_cyc = cyc + 17;
        sb.push_back(e);
        check("busy_after_accept", int'(bus.busy), 1);
    endtask

    task automatic issue(input int n, input int d);
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = 16'(n);
        bus.divisor  = 8'(d);
        @(posedge clk);
        #1;
        push_exp(n, d);
        bus.start    = 1'b0;
        bus.dividend = 16'($urandom);
        bus.divisor  = 8'($urandom);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bus.done) return;
        end
        checks++;
        failures++;
        $display("FAIL done_timeout: got no done in 60 cycles, expected done");
    endtask

    task automatic run_div(input int n, input int d);
        issue(n, d);
        wait_done();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int dir_n[16] = '{100, -100, 100, -100, -16384, 16256, -32768, -16256,
                          127, 5, -32768, 32767, 0, -128, 127, -1};
        int dir_d[16] = '{7, 7, -7, -7, -128, -128, 1, -128,
                          127, 0, -128, -1, 5, -1, -1, 1};
        int n;
        int d;
        logic [15:0] t16;
        logic [7:0]  t8;

        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_busy", int'(bus.busy), 0);
        check("reset_done", int'(bus.done), 0);
        check("reset_quotient", int'(bus.quotient), 0);
        check("reset_remainder", int'(bus.remainder), 0);
        check("reset_overflow", int'(bus.overflow), 0);
        check("reset_div_by_zero", int'(bus.div_by_zero), 0);
        rst = 1'b0;

        // Directed signs, boundaries, round-trips and divide-by-zero.
        for (int i = 0; i < 16; i++) run_div(dir_n[i], dir_d[i]);

        // A start pulse mid-CALC with other operands must be ignored.
        issue(1234, 56);
        repeat (5) @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = 16'(-1000);
        bus.divisor  = 8'(3);
        @(negedge clk);
        bus.start = 1'b0;
        wait_done();
        repeat (4) @(negedge clk);

        // Reset in the middle of CALC after a held non-zero result.
        run_div(100, 7);
        issue(1000, 7);
        repeat (8) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midreset_busy", int'(bus.busy), 0);
        check("midreset_done", int'(bus.done), 0);
        check("midreset_quotient", int'(bus.quotient), 0);
        check("midreset_remainder", int'(bus.remainder), 0);
        check("midreset_overflow", int'(bus.overflow), 0);
        check("midreset_div_by_zero", int'(bus.div_by_zero), 0);
        sb.delete();
        rst = 1'b0;
        repeat (20) @(negedge clk);
        run_div(1000, 10);

        // Start held high across done: second operation accepted in the done cycle.
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = 16'(5000);
        bus.divisor  = 8'(77);
        @(posedge clk);
        #1;
        push_exp(5000, 77);
        bus.dividend = 16'(-3000);
        bus.divisor  = 8'(-50);
        wait_done();
        @(posedge clk);
        #1;
        push_exp(-3000, -50);
        bus.start = 1'b0;
        wait_done();

        // Random operands: half raw 16-bit dividends, half near products of the divisor.
        for (int i = 0; i < 60; i++) begin
            t8 = 8'($urandom);
            d  = int'($signed(t8));
            if (i % 2 == 0) begin
                t16 = 16'($urandom);
                n   = int'($signed(t16));
            end else begin
                n = (int'($urandom_range(0, 255)) - 128) * d + int'($urandom_range(0, 20)) - 10;
            end
            run_div(n, d);
        end

        repeat (25) @(negedge clk);
        check("scoreboard_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/divider.md
# divider

Sequential signed divider for the arithmetic unit: the inverse of the 8×8 Booth multiplier. It divides a 16-bit signed dividend, such as a multiplier product, by an 8-bit signed divisor and returns an 8-bit signed quotient and an 8-bit signed remainder. It uses radix-2 restoring division on magnitudes, one quotient bit per cycle, with a start/done handshake. Latency is fixed and does not depend on the operands.

## Interface
Parameters:
- DW, 8: divisor, quotient and remainder width.
- NW, 16: dividend width. Fixed at 2*DW.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request. Sampled only while idle (IDLE or DONE state).
- dividend  in  16  signed dividend. Captured on the accepted start edge.
- divisor  in  8  signed divisor. Captured on the accepted start edge.
- busy  out  1  high from the cycle after acceptance until the result edge.
- done  out  1  one-cycle pulse: results valid.
- quotient  out  8  signed quotient, truncated toward zero.
- remainder  out  8  signed remainder. Its sign follows the dividend.
- overflow  out  1  true quotient outside [-128, 127].
- div_by_zero  out  1  divisor was 0.

## Operation
- States: IDLE, CALC, FIX, DONE.
  - IDLE or DONE with start=1 → CALC.
  - IDLE with start=0 → IDLE.
  - DONE with start=0 → IDLE.
  - CALC with count=15 → FIX.
  - FIX → DONE.
- Accept edge:
  - Latch sign_q = dividend[15]^divisor[7] and sign_r = dividend[15].
  - Latch |dividend| as 17 bits, so -32768 gives 32768.
  - Latch |divisor| as 9 bits, so -128 gives 128.
  - Clear the 9-bit partial remainder and count.
- CALC iteration:
  - Shift the partial remainder left by one and bring in the next dividend magnitude bit, MSB first.
  - Trial-subtract |divisor|. If the result is non-negative, keep it and shift in quotient bit 1; otherwise restore and shift in 0.
  - The quotient magnitude register is 16 bits.
- FIX edge:
  - Negate the quotient if sign_q is set. Negate the remainder if sign_r is set.
  - Overflow when the quotient magnitude exceeds 127 with sign_q=0, or exceeds 128 with sign_q=1.
  - Remainder magnitude is always ≤127, so the remainder never overflows.
- Result registers are written on the DONE-entry edge:
  - Normal: quotient and remainder from FIX; overflow=0; div_by_zero=0.
  - overflow=1: quotient=0, remainder=0.
  - div_by_zero=1: quotient=0, remainder=0, overflow=0. The CALC cycles still run, so latency is unchanged.
- Results and flags hold until the next DONE entry.
- Reset values: busy=0, done=0, quotient=0, remainder=0, overflow=0, div_by_zero=0, state=IDLE, count=0.

## Timing
- Start accepted at edge E0.
  - busy=1 after E0.
  - Iterations run on E1..E16; FIX is the state after E16.
  - E17 writes the results. done=1 and busy=0 for the cycle after E17.
- Latency is 17 clock edges, start edge to done, for every operand pair including divide-by-zero.
- start while busy is ignored and has no effect on the latched operands.
- start during the done cycle is accepted, which gives back-to-back throughput of one result per 17 cycles. done then drops after one cycle.
- Operand inputs are don't-care except on the accept edge.
- rst=1 at any edge, including mid-CALC, returns all outputs and state to reset values on that edge. A partial result is never flagged done.

## Structure
- Package div_pkg holds:
  - The state enum: IDLE, CALC, FIX, DONE.
  - Constants DW=8, NW=16, and ITER=16.
  - Limits QMAX_POS=127 and QMAX_NEG=128.
- One combinational sub-module, div_step: one restoring iteration.
  - Inputs: 9-bit partial remainder, incoming dividend bit, 9-bit divisor magnitude.
  - Outputs: next partial remainder and quotient bit.
- The top level holds the FSM, counter, operand registers, sign fix, and result registers.

## Test plan
- 100 / 7 → quotient=14 (0x0E), remainder=2, flags 0. done exactly 17 edges after start, one cycle wide.
- Sign cases:
  - -100 / 7 → quotient=0xF2 (-14), remainder=0xFE (-2).
  - 100 / -7 → quotient=0xF2, remainder=2.
  - -100 / -7 → quotient=14, remainder=0xFE.
- Boundaries:
  - -16384 / 128 is not a legal input, since +128 is outside the 8-bit signed divisor range.
  - -16384 / -128 (0xC000 / 0x80) → overflow=1, quotient=0, remainder=0, because 128 does not fit.
  - 16256 / -128 → quotient=0x81 (-127), remainder=0.
  - -32768 / 1 → overflow=1.
- Product round-trip: -16256 (127 × -128) / -128 → quotient=127, remainder=0. 127 / 127 → quotient=1, remainder=0.
- 5 / 0 → div_by_zero=1, quotient=0, remainder=0, overflow=0, with the same 17-edge latency.
- Control:
  - Pulse start again mid-CALC with different operands: ignored, and the first result is unchanged.
  - Assert rst at iteration 8: next cycle busy=0, done=0, all outputs 0.
  - Then 1000 / 10 → quotient=100, remainder=0.
  - Start held high across done → second result exactly 17 edges later.
